// File: rtl/dl_lshift_arb_pkg.sv
// Shared defaults for the round-robin left-shift arbiter.
// Derived widths stay local to each module.
package dl_lshift_arb_pkg;
  localparam int DEF_NUM_BITS = 32;
  localparam int DEF_NUM_REQ  = 4;
endpackage

// File: rtl/dl_lshift.sv
// Combinational logical left shifter: zero fill, result truncated to NUM_BITS.
module dl_lshift #(
  parameter  int NUM_BITS       = 32,
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic [NUM_BITS-1:0]       i_data,
  input  logic [NUM_SHIFT_BITS-1:0] i_shamt,
  output logic [NUM_BITS-1:0]       o_data
);
  assign o_data = i_data << i_shamt;
endmodule

// File: rtl/dl_lshift_arb.sv
// Round-robin arbiter time-sharing one left shifter among NUM_REQ requesters.
// Registered, id-tagged valid/ready result channel with one-cycle latency.
module dl_lshift_arb
  import dl_lshift_arb_pkg::*;
#(
  parameter  int NUM_BITS       = DEF_NUM_BITS,
  parameter  int NUM_REQ        = DEF_NUM_REQ,
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS),
  localparam int ID_BITS        = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*NUM_BITS-1:0]         req_in,
  input  logic [NUM_REQ*NUM_SHIFT_BITS-1:0]   req_shamt,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_BITS-1:0]                 out_data,
  output logic [ID_BITS-1:0]                  out_id
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both high; valid never waits on ready, ready may follow valid.

  logic                      r_out_valid;
  logic [NUM_BITS-1:0]       r_out_data;
  logic [ID_BITS-1:0]        r_out_id;
  logic [ID_BITS-1:0]        r_rr_ptr;

  logic                      w_load_en;
  logic                      w_any;
  logic                      w_xfer;
  logic [ID_BITS-1:0]        w_winner;
  logic [ID_BITS-1:0]        w_next_ptr;
  logic [NUM_REQ-1:0]        w_grant;
  logic [NUM_BITS-1:0]       w_sel_data;
  logic [NUM_SHIFT_BITS-1:0] w_sel_shamt;
  logic [NUM_BITS-1:0]       w_shift;

  assign w_load_en = ~r_out_valid | out_ready;

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    int idx;
    idx      = 0;
    w_any    = 1'b0;
    w_winner = '0;
    w_grant  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_any && req_valid[idx]) begin
        w_any        = 1'b1;
        w_winner     = idx[ID_BITS-1:0];
        w_grant[idx] = 1'b1;
      end
    end
  end

  assign req_ready  = w_load_en ? w_grant : '0;
  assign w_xfer     = w_load_en & w_any;
  assign w_next_ptr = (w_winner == ID_BITS'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

  assign w_sel_data  = req_in[w_winner*NUM_BITS +: NUM_BITS];
  assign w_sel_shamt = req_shamt[w_winner*NUM_SHIFT_BITS +: NUM_SHIFT_BITS];

  dl_lshift #(
    .NUM_BITS (NUM_BITS)
  ) u_lshift (
    .i_data  (w_sel_data),
    .i_shamt (w_sel_shamt),
    .o_data  (w_shift)
  );

  // Drain without a new winner only clears valid; data and id keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load_en) begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_shift;
        r_out_id    <= w_winner;
        r_rr_ptr    <= w_next_ptr;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;

endmodule

// File: tb/tb_dl_lshift_arb.sv
// Directed, table-driven bench for dl_lshift_arb (NUM_BITS=32, NUM_REQ=4).
module tb_dl_lshift_arb;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_in;
  logic [19:0]  req_shamt;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_id;

  int n_checks;
  int n_errors;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]   valid;
    logic [127:0] din;
    logic [19:0]  sh;
    logic         ordy;
    logic [3:0]   rr;
    logic         ov;
    logic [31:0]  d;
    logic [1:0]   id;
  } vec_t;

  vec_t vt[14];

  dl_lshift_arb #(
    .NUM_BITS (32),
    .NUM_REQ  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in    (req_in),
    .req_shamt (req_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Non-winning lanes carry distinct filler so a wrong mux select shows up.
  function automatic vec_t mk(input logic [3:0] valid, input int lane, input logic [31:0] din,
                              input logic [4:0] sh, input logic ordy, input logic [3:0] rr,
                              input logic ov, input logic [31:0] d, input logic [1:0] id);
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      v.din[i*32 +: 32] = 32'hDEAD_0000 | 32'(i);
      v.sh[i*5 +: 5]    = 5'(i + 1);
    end
    v.din[lane*32 +: 32] = din;
    v.sh[lane*5 +: 5]    = sh;
    v.valid = valid;
    v.ordy  = ordy;
    v.rr    = rr;
    v.ov    = ov;
    v.d     = d;
    v.id    = id;
    return v;
  endfunction

  // driver: called just after a rising edge; checks ready, then the registered result
  task automatic apply_vec(input vec_t v, input int n);
    req_valid = v.valid;
    req_in    = v.din;
    req_shamt = v.sh;
    out_ready = v.ordy;
    #1;
    chk($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(v.rr));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", n), 32'(out_valid), 32'(v.ov));
    chk($sformatf("v%0d out_data", n), out_data, v.d);
    chk($sformatf("v%0d out_id", n), 32'(out_id), 32'(v.id));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_in    = '0;
    req_shamt = '0;
    out_ready = 1'b1;

    vt[0]  = mk(4'b0001, 0, 32'h0000_0001, 5'd5,  1'b1, 4'b0001, 1'b1, 32'h0000_0020, 2'd0);
    vt[1]  = mk(4'b0000, 0, 32'h0000_0000, 5'd0,  1'b1, 4'b0000, 1'b0, 32'h0000_0020, 2'd0);
    vt[2]  = mk(4'b1000, 3, 32'h8000_0001, 5'd31, 1'b1, 4'b1000, 1'b1, 32'h8000_0000, 2'd3);
    vt[3]  = mk(4'b0100, 2, 32'h8000_0001, 5'd0,  1'b1, 4'b0100, 1'b1, 32'h8000_0001, 2'd2);
    vt[4]  = mk(4'b0010, 1, 32'h0000_00F3, 5'd4,  1'b1, 4'b0010, 1'b1, 32'h0000_0F30, 2'd1);
    vt[5]  = mk(4'b1111, 2, 32'hFFFF_FFFF, 5'd16, 1'b1, 4'b0100, 1'b1, 32'hFFFF_0000, 2'd2);
    vt[6]  = mk(4'b0011, 0, 32'h1234_5678, 5'd8,  1'b1, 4'b0001, 1'b1, 32'h3456_7800, 2'd0);
    vt[7]  = mk(4'b0011, 1, 32'h0000_0003, 5'd30, 1'b1, 4'b0010, 1'b1, 32'hC000_0000, 2'd1);
    vt[8]  = mk(4'b1001, 3, 32'h0000_0005, 5'd1,  1'b0, 4'b0000, 1'b1, 32'hC000_0000, 2'd1);
    vt[9]  = mk(4'b1001, 3, 32'h0000_0005, 5'd1,  1'b0, 4'b0000, 1'b1, 32'hC000_0000, 2'd1);
    vt[10] = mk(4'b1001, 3, 32'h0000_0005, 5'd1,  1'b0, 4'b0000, 1'b1, 32'hC000_0000, 2'd1);
    vt[11] = mk(4'b1001, 3, 32'h0000_0005, 5'd1,  1'b1, 4'b1000, 1'b1, 32'h0000_000A, 2'd3);
    vt[12] = mk(4'b1001, 0, 32'h0000_000F, 5'd4,  1'b1, 4'b0001, 1'b1, 32'h0000_00F0, 2'd0);
    vt[13] = mk(4'b0000, 0, 32'h0000_0000, 5'd0,  1'b1, 4'b0000, 1'b0, 32'h0000_00F0, 2'd0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset out_id", 32'(out_id), 32'd0);
    chk("reset req_ready idle", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 14; n++) apply_vec(vt[n], n);

    // pointer is 1 here: load a result, then pull reset between edges
    apply_vec(mk(4'b0010, 1, 32'h0000_0007, 5'd2, 1'b1, 4'b0010, 1'b1, 32'h0000_001C, 2'd1), 14);
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async out_data", out_data, 32'd0);
    chk("async out_id", 32'(out_id), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // fairness after reset: rotation must restart at requester 0
    for (int i = 0; i < 8; i++) exp_q.push_back({30'(32'd1 << (i % 4)), 2'(i % 4)});
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_in[i*32 +: 32]  = 32'h0000_0001;
      req_shamt[i*5 +: 5] = 5'(i);
    end
    for (int c = 0; c < 8; c++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      #1;
      chk($sformatf("rr c%0d req_ready", c), 32'(req_ready), 32'd1 << e[1:0]);
      @(posedge clk);
      #1;
      chk($sformatf("rr c%0d out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("rr c%0d out_id", c), 32'(out_id), 32'(e[1:0]));
      chk($sformatf("rr c%0d out_data", c), out_data, 32'(e[31:2]));
    end

    // final drain
    req_valid = '0;
    @(posedge clk);
    #1;
    chk("final drain out_valid", 32'(out_valid), 32'd0);
    chk("final drain out_data", out_data, 32'h0000_0008);
    chk("final drain out_id", 32'(out_id), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
